tc_register_file: RTL and testbench

- Multi-entry successor to the single TC register.
- DEPTH words of BIT_WIDTH bits, one write port and NUM_READ independent read ports.
- Keeps the TC two-phase timing: reads sample on the rising edge, writes commit on the falling edge.
- Read outputs float to high-Z when their port is not loaded, so they can share a TC bus. Used as the CPU general-purpose register bank.

---
 rtl/tc_regfile_pkg.sv | 19 +
 rtl/tc_regfile_read_port.sv | 41 ++++
 rtl/tc_register_file.sv | 58 +++++
 tb/tb_tc_register_file.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tc_regfile_pkg.sv
// Shared helpers for the TC register file: address sizing, constant words and
// the packed-bus slice convention (port p occupies [p*W +: W]).
package tc_regfile_pkg;

  localparam int MAX_WORD_W = 1024;
  localparam logic [MAX_WORD_W-1:0] WORD_ALL_Z = 'z;
  localparam logic [MAX_WORD_W-1:0] WORD_ALL_0 = '0;

  function automatic int addr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/tc_regfile_read_port.sv
// One read port: posedge capture of the addressed word, tri-stated when not loaded.
module tc_regfile_read_port
  import tc_regfile_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = addr_width(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic [DEPTH*BIT_WIDTH-1:0] words,
  output logic [BIT_WIDTH-1:0]       rd
);

  logic [BIT_WIDTH-1:0] sel;
  logic [BIT_WIDTH-1:0] data_q;
  logic                 en_q;

  // Addresses at or beyond DEPTH match no word and fall through to zero.
  always_comb begin
    sel = WORD_ALL_0[BIT_WIDTH-1:0];
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) sel = words[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      data_q <= '0;
    end else begin
      en_q <= load;
      if (load) data_q <= sel;
    end
  end

  assign rd = en_q ? data_q : WORD_ALL_Z[BIT_WIDTH-1:0];

endmodule

// File: rtl/tc_register_file.sv
// TC register bank: negedge write port, NUM_READ posedge read ports with Z outputs.
// Build option TC_REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module tc_register_file
  import tc_regfile_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_READ  = 2,
  parameter int ADDR_W    = addr_width(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          save,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [BIT_WIDTH-1:0]          in,
  input  logic [NUM_READ-1:0]           load,
  input  logic [NUM_READ*ADDR_W-1:0]    raddr,
  output logic [NUM_READ*BIT_WIDTH-1:0] out
);

`ifdef TC_REGFILE_ZERO_REG_EN
  localparam int FIRST_RW = 1;
`else
  localparam int FIRST_RW = 0;
`endif

  logic [DEPTH*BIT_WIDTH-1:0] words;

  // Each word decodes its own address; out-of-range waddr selects nothing.
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    if (w < FIRST_RW) begin : g_zero
      assign words[w*BIT_WIDTH +: BIT_WIDTH] = '0;
    end else begin : g_reg
      logic [BIT_WIDTH-1:0] word_q;
      always_ff @(negedge clk or posedge rst) begin
        if (rst) word_q <= '0;
        else if (save && (waddr == ADDR_W'(w))) word_q <= in;
      end
      assign words[w*BIT_WIDTH +: BIT_WIDTH] = word_q;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rport
    tc_regfile_read_port #(
      .BIT_WIDTH (BIT_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W)
    ) u_rport (
      .clk   (clk),
      .rst   (rst),
      .load  (load[p]),
      .raddr (raddr[slice_lo(p, ADDR_W) +: ADDR_W]),
      .words (words),
      .rd    (out[slice_lo(p, BIT_WIDTH) +: BIT_WIDTH])
    );
  end

endmodule

// File: tb/tb_tc_register_file.sv
// Scoreboard bench for tc_register_file (DEPTH=6 so out-of-range addresses exist).
module tb_tc_register_file;

  localparam int W = 8;

  typedef struct packed {
    bit         z1;
    bit [W-1:0] d1;
    bit         z0;
    bit [W-1:0] d0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         save = 1'b0;
  logic [2:0]   waddr = '0;
  logic [W-1:0] in_d = '0;
  logic [1:0]   load = '0;
  logic [5:0]   raddr = '0;
  wire  [15:0]  out_bus;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  tc_register_file #(.BIT_WIDTH(W), .DEPTH(6), .NUM_READ(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .save  (save),
    .waddr (waddr),
    .in    (in_d),
    .load  (load),
    .raddr (raddr),
    .out   (out_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input bit ok, input logic [W-1:0] act,
                     input bit exp_z, input bit [W-1:0] exp_d);
    n_checks++;
    if (!ok) begin
      n_fail++;
      if (exp_z) $display("FAIL %s: got %h, expected zz", name, act);
      else       $display("FAIL %s: got %h, expected %h", name, act, exp_d);
    end
  endtask

  // Monitor: outputs are stable between posedges, so compare at negedge.
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ok = e.z0 ? (out_bus[7:0] === 8'hzz) : (out_bus[7:0] === e.d0);
        chk("port0", ok, out_bus[7:0], e.z0, e.d0);
        ok = e.z1 ? (out_bus[15:8] === 8'hzz) : (out_bus[15:8] === e.d1);
        chk("port1", ok, out_bus[15:8], e.z1, e.d1);
      end
    end
  end

  // One cycle: drive, read at posedge, write at negedge.
  task automatic step(input bit s, input bit [2:0] wa, input bit [W-1:0] wd,
                      input bit [1:0] ld, input bit [2:0] ra1, input bit [2:0] ra0,
                      input bit z1, input bit [W-1:0] d1,
                      input bit z0, input bit [W-1:0] d0);
    exp_t e;
    save  = s;
    waddr = wa;
    in_d  = wd;
    load  = ld;
    raddr = {ra1, ra0};
    e.z1 = z1; e.d1 = d1; e.z0 = z0; e.d0 = d0;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    #1 rst = 1'b1;
    // Reset holds outputs Z even with both ports loaded.
    step(0, 0, 8'h00, 2'b11, 3'd0, 3'd0, 1, 8'h00, 1, 8'h00);
    step(1, 3, 8'hEE, 2'b11, 3'd3, 3'd3, 1, 8'h00, 1, 8'h00);
    rst = 1'b0;
    step(0, 0, 8'h00, 2'b01, 3'd0, 3'd3, 1, 8'h00, 0, 8'h00);
    // Read sampled before the same-cycle write sees the old value.
    step(1, 2, 8'hA5, 2'b01, 3'd0, 3'd2, 1, 8'h00, 0, 8'h00);
    step(0, 0, 8'h00, 2'b10, 3'd2, 3'd0, 0, 8'hA5, 1, 8'h00);
    step(1, 1, 8'h11, 2'b00, 3'd0, 3'd0, 1, 8'h00, 1, 8'h00);
    step(1, 4, 8'h44, 2'b00, 3'd0, 3'd0, 1, 8'h00, 1, 8'h00);
    step(0, 0, 8'h00, 2'b11, 3'd4, 3'd1, 0, 8'h44, 0, 8'h11);
    step(0, 0, 8'h00, 2'b11, 3'd1, 3'd1, 0, 8'h11, 0, 8'h11);
    step(0, 0, 8'h00, 2'b01, 3'd1, 3'd1, 1, 8'h00, 0, 8'h11);
    // Out-of-range write and read.
    step(1, 7, 8'hFF, 2'b11, 3'd7, 3'd6, 0, 8'h00, 0, 8'h00);
    step(1, 6, 8'hFE, 2'b11, 3'd2, 3'd1, 0, 8'hA5, 0, 8'h11);
    step(0, 0, 8'h00, 2'b11, 3'd4, 3'd3, 0, 8'h44, 0, 8'h00);
    step(0, 0, 8'h00, 2'b11, 3'd0, 3'd5, 0, 8'h00, 0, 8'h00);
    step(0, 0, 8'h00, 2'b11, 3'd7, 3'd7, 0, 8'h00, 0, 8'h00);
    // Reset rising between posedge and negedge with a write pending.
    save = 1'b1; waddr = 3'd5; in_d = 8'h5A; load = 2'b11; raddr = {3'd5, 3'd1};
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    ok = (out_bus[7:0] === 8'hzz);
    chk("rst_async_p0", ok, out_bus[7:0], 1, 8'h00);
    ok = (out_bus[15:8] === 8'hzz);
    chk("rst_async_p1", ok, out_bus[15:8], 1, 8'h00);
    @(negedge clk);
    #1 rst = 1'b0;
    save = 1'b0;
    step(0, 0, 8'h00, 2'b11, 3'd5, 3'd2, 0, 8'h00, 0, 8'h00);
    // Register 0 behaviour depends on the build option.
    step(1, 0, 8'h77, 2'b00, 3'd0, 3'd0, 1, 8'h00, 1, 8'h00);
`ifdef TC_REGFILE_ZERO_REG_EN
    step(0, 0, 8'h00, 2'b01, 3'd0, 3'd0, 1, 8'h00, 0, 8'h00);
`else
    step(0, 0, 8'h00, 2'b01, 3'd0, 3'd0, 1, 8'h00, 0, 8'h77);
`endif
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
